btb_ctrl: RTL
=============

# btb_ctrl

Sequencing controller for the 2-way, 8-set branch target buffer. It owns the BTB set array and the per-set LRU bits, and clears the array after reset or flush. It serves fetch-stage lookups with a registered one-cycle prediction. It runs execute-stage branch-resolution updates as a read-modify-write sequence through a small FSM, and arbitrates the single array write port between initialisation, updates and lookup LRU refresh.

## Interface
- SETS, 8, number of sets (power of two)
- INDEX_W, 3, log2(SETS); index = pc[INDEX_W+1:2]
- TAG_W, 27, tag = pc[31:INDEX_W+2]
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- flush  in  1  one-cycle pulse; re-initialises the array
- lookup_valid  in  1  fetch lookup request
- lookup_pc  in  32  fetch PC
- lookup_ready  out  1  lookup accepted this cycle
- pred_valid  out  1  registered: BTB hit for the accepted lookup
- pred_taken  out  1  registered: state[1] of the hit entry
- pred_target  out  32  registered: target of the hit entry, 0 on miss
- upd_valid  in  1  resolved-branch update request
- upd_ready  out  1  update accepted when upd_valid && upd_ready
- upd_pc  in  32  branch PC
- upd_taken  in  1  resolved direction
- upd_target  in  32  resolved target
- busy  out  1  FSM not in IDLE

## Operation
- Entry (64 b): [63] valid, [62:36] tag, [35:4] target, [3:2] 2-bit state, [1:0] reserved, written 0. Set = {way0 in [127:64], way1 in [63:0]}.
- States: SNT=00, WNT=01, WT=10, ST=11. Prediction is taken iff state[1]=1.
- LRU[i] records the most recently used way of set i. The victim is an invalid way if one exists, way0 first. Otherwise the victim is way !LRU[i].
- FSM states: INIT, IDLE, UPD_RD, UPD_WR.
  - INIT: counter 0..SETS-1 writes an all-zero set and clears LRU[counter]. After the last set, go to IDLE.
  - IDLE: upd_ready=1. On handshake, capture the upd_* fields and go to UPD_RD.
  - UPD_RD: read the set and compute hit/way.
    - Hit: merge into the hit way and go to UPD_WR. State saturates +1 if taken, −1 if not taken. Target is replaced only if taken.
    - Miss and taken: allocate the victim with valid=1, tag, target, state=WT, then go to UPD_WR.
    - Miss and not taken: no write; go to IDLE.
  - UPD_WR: write the merged set and set LRU[idx] to the written way, then go to IDLE.
- Lookup: lookup_ready=1 in IDLE and UPD_RD, 0 in INIT and UPD_WR.
  - On an accepted lookup, the hit/target/state are registered to the pred_* outputs.
  - A hit also sets LRU[idx] to the hit way.
  - With no lookup, or with lookup_ready=0, the next cycle has pred_valid=0.
- Simultaneous LRU write to the same set from a lookup and from UPD_WR: the update wins.
- A lookup in UPD_RD sees pre-update contents.
- flush in any state: go to INIT with counter=0 and drop the captured update. Contents written earlier stay until INIT overwrites them.
- rst has priority over flush. It forces INIT with counter=0 and all outputs to reset values.

## Timing
- Reset values: pred_valid=0, pred_taken=0, pred_target=0, lookup_ready=0, upd_ready=0, busy=1. The FSM is in INIT with counter=0.
- After rst deasserts, INIT occupies cycles 0..7. IDLE is reached, and lookup_ready=upd_ready=1, on cycle 8.
- Lookup latency is 1 cycle: a request accepted in cycle T gives pred_* valid in cycle T+1.
- Update (hit or allocate): handshake in T, UPD_RD in T+1, UPD_WR in T+2. A lookup accepted at T+3 or later sees the new entry. upd_ready=1 again at T+3.
- Update (miss, not taken): upd_ready=1 again at T+2, with no array write.
- Throughput is at most one update per 3 cycles. Lookups are stalled exactly one cycle per written update.
- State arithmetic saturates: ST+taken=ST and SNT+not-taken=SNT. There is no wrap.

## Structure
- Package btb_pkg holds:
  - the SETS/INDEX_W/TAG_W defaults;
  - the bit positions of the entry fields;
  - the state encodings SNT/WNT/WT/ST;
  - the FSM state enum.
- One combinational sub-module, btb_entry_merge. Inputs: old set, captured update fields, LRU bit. Outputs: new set, write-enable, written way. The same hit logic is reused for the lookup path.

## Test plan
- Reset release: busy=1 for 8 cycles, then lookup_ready=1. A lookup of pc 0x0000_1000 gives pred_valid=0, pred_target=0.
- Allocate: taken update, pc 0x0000_1000, target 0x0000_2000. A lookup at T+3 gives pred_valid=1, pred_taken=1 (WT), pred_target=0x0000_2000.
- Saturation:
  - From the WT entry above, three taken updates: first gives ST, rest stay ST.
  - Then four not-taken updates: ST→WT→WNT→SNT→SNT; pred_taken=0 after the second.
- Replacement in set 0:
  - Allocate pc 0x0000_0000 (way0) and pc 0x0000_0020 (way1).
  - Look up 0x0000_0000, which sets LRU[0]=way0.
  - Allocate 0x0000_0040: it evicts way1. 0x0000_0020 now misses; 0x0000_0000 still hits.
- Not-taken miss on pc 0x0000_3000: upd_ready=1 at T+2, and a later lookup still misses.
- flush asserted in UPD_RD: the update is dropped, 8 INIT cycles follow, and all previous entries miss afterwards.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared constants, entry field layout and helper functions for the 2-way BTB controller.
package btb_pkg;

    localparam int unsigned BTB_SETS    = 8;
    localparam int unsigned BTB_INDEX_W = 3;
    localparam int unsigned BTB_TAG_W   = 27;

    localparam int unsigned ENTRY_W = 64;
    localparam int unsigned SET_W   = 2 * ENTRY_W;

    localparam int unsigned VALID_BIT = 63;
    localparam int unsigned TAG_MSB   = 62;
    localparam int unsigned TAG_LSB   = 36;
    localparam int unsigned TGT_MSB   = 35;
    localparam int unsigned TGT_LSB   = 4;
    localparam int unsigned ST_MSB    = 3;
    localparam int unsigned ST_LSB    = 2;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic [1:0] {
        FSM_INIT   = 2'd0,
        FSM_IDLE   = 2'd1,
        FSM_UPD_RD = 2'd2,
        FSM_UPD_WR = 2'd3
    } fsm_e;

    // Way 0 lives in the upper half of a set, way 1 in the lower half.
    function automatic logic [ENTRY_W-1:0] get_way(input logic [SET_W-1:0] s, input logic way);
        return way ? s[ENTRY_W-1:0] : s[SET_W-1:ENTRY_W];
    endfunction

    // Returns {hit, hit_way}.
    function automatic logic [1:0] set_hit(input logic [SET_W-1:0] s,
                                           input logic [BTB_TAG_W-1:0] tag);
        logic h0;
        logic h1;
        h0 = s[ENTRY_W + VALID_BIT] && (s[ENTRY_W + TAG_MSB -: BTB_TAG_W] == tag);
        h1 = s[VALID_BIT] && (s[TAG_MSB -: BTB_TAG_W] == tag);
        return {h0 | h1, !h0 && h1};
    endfunction

    function automatic logic [1:0] sat_state(input logic [1:0] s, input logic taken);
        if (taken) begin
            return (s == ST) ? ST : s + 2'd1;
        end
        return (s == SNT) ? SNT : s - 2'd1;
    endfunction

endpackage

// File: rtl/btb_entry_merge.sv
// Combinational merge of a resolved branch into one BTB set: hit update or victim allocation.
module btb_entry_merge
    import btb_pkg::*;
(
    input  logic [SET_W-1:0]     old_set,
    input  logic [BTB_TAG_W-1:0] tag,
    input  logic                 taken,
    input  logic [31:0]          target,
    input  logic                 lru,
    output logic [SET_W-1:0]     new_set,
    output logic                 we,
    output logic                 way
);

    logic [1:0]         hit_info;
    logic [ENTRY_W-1:0] e0;
    logic [ENTRY_W-1:0] e1;
    logic [ENTRY_W-1:0] old_e;
    logic [ENTRY_W-1:0] new_e;

    always_comb begin
        hit_info = set_hit(old_set, tag);
        e0       = get_way(old_set, 1'b0);
        e1       = get_way(old_set, 1'b1);
        old_e    = '0;
        new_e    = '0;
        we       = 1'b0;
        way      = 1'b0;
        new_set  = old_set;
        if (hit_info[1]) begin
            way   = hit_info[0];
            old_e = way ? e1 : e0;
            new_e = old_e;
            new_e[ST_MSB:ST_LSB] = sat_state(old_e[ST_MSB:ST_LSB], taken);
            if (taken) begin
                new_e[TGT_MSB:TGT_LSB] = target;
            end
            we = 1'b1;
        end else if (taken) begin
            // Prefer an empty way (way 0 first); otherwise evict the least recently used.
            if (!e0[VALID_BIT]) begin
                way = 1'b0;
            end else if (!e1[VALID_BIT]) begin
                way = 1'b1;
            end else begin
                way = !lru;
            end
            new_e[VALID_BIT]       = 1'b1;
            new_e[TAG_MSB:TAG_LSB] = tag;
            new_e[TGT_MSB:TGT_LSB] = target;
            new_e[ST_MSB:ST_LSB]   = WT;
            we = 1'b1;
        end
        if (way) begin
            new_set[ENTRY_W-1:0] = new_e;
        end else begin
            new_set[SET_W-1:ENTRY_W] = new_e;
        end
    end

endmodule

// File: rtl/btb_ctrl.sv
// BTB sequencing controller: array init, registered lookups and read-modify-write updates.
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int unsigned SETS    = BTB_SETS,
    parameter int unsigned INDEX_W = BTB_INDEX_W,
    parameter int unsigned TAG_W   = BTB_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        lookup_valid,
    input  logic [31:0] lookup_pc,
    output logic        lookup_ready,
    output logic        pred_valid,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        busy
);

    logic [SET_W-1:0]   set_mem [SETS];
    logic [SETS-1:0]    lru_q;
    fsm_e               state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;

    logic [INDEX_W-1:0] upd_idx_q;
    logic [TAG_W-1:0]   upd_tag_q;
    logic               upd_taken_q;
    logic [31:0]        upd_target_q;
    logic [SET_W-1:0]   wr_set_q;
    logic               wr_way_q;

    logic [SET_W-1:0]   mrg_set;
    logic               mrg_we;
    logic               mrg_way;

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [1:0]         lk_hit;
    logic [ENTRY_W-1:0] lk_entry;
    logic               lk_accept;
    logic               unused_bits;

    assign lookup_ready = (state_q == FSM_IDLE) || (state_q == FSM_UPD_RD);
    assign upd_ready    = (state_q == FSM_IDLE);
    assign busy         = (state_q != FSM_IDLE);

    assign lk_idx    = lookup_pc[INDEX_W+1:2];
    assign lk_tag    = lookup_pc[31:INDEX_W+2];
    assign lk_hit    = set_hit(set_mem[lk_idx], lk_tag);
    assign lk_entry  = get_way(set_mem[lk_idx], lk_hit[0]);
    assign lk_accept = lookup_valid && lookup_ready;

    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0], lk_entry[ENTRY_W-1:TGT_MSB+1],
                           lk_entry[ST_LSB:0]};

    btb_entry_merge u_merge (
        .old_set (set_mem[upd_idx_q]),
        .tag     (upd_tag_q),
        .taken   (upd_taken_q),
        .target  (upd_target_q),
        .lru     (lru_q[upd_idx_q]),
        .new_set (mrg_set),
        .we      (mrg_we),
        .way     (mrg_way)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            FSM_INIT: begin
                cnt_d = cnt_q + INDEX_W'(1);
                if (cnt_q == INDEX_W'(SETS - 1)) begin
                    state_d = FSM_IDLE;
                end
            end
            FSM_IDLE:   if (upd_valid) state_d = FSM_UPD_RD;
            FSM_UPD_RD: state_d = mrg_we ? FSM_UPD_WR : FSM_IDLE;
            FSM_UPD_WR: state_d = FSM_IDLE;
            default:    state_d = FSM_INIT;
        endcase
        if (flush) begin
            state_d = FSM_INIT;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FSM_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == FSM_IDLE && upd_valid) begin
            upd_idx_q    <= upd_pc[INDEX_W+1:2];
            upd_tag_q    <= upd_pc[31:INDEX_W+2];
            upd_taken_q  <= upd_taken;
            upd_target_q <= upd_target;
        end
        if (state_q == FSM_UPD_RD) begin
            wr_set_q <= mrg_set;
            wr_way_q <= mrg_way;
        end
    end

    // Update write comes last so it wins any LRU collision with a lookup hit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == FSM_INIT) begin
                set_mem[cnt_q] <= '0;
                lru_q[cnt_q]   <= 1'b0;
            end
            if (lk_accept && lk_hit[1]) begin
                lru_q[lk_idx] <= lk_hit[0];
            end
            if (state_q == FSM_UPD_WR && !flush) begin
                set_mem[upd_idx_q] <= wr_set_q;
                lru_q[upd_idx_q]   <= wr_way_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else begin
            pred_valid  <= lk_accept && lk_hit[1];
            pred_taken  <= lk_accept && lk_hit[1] && lk_entry[ST_MSB];
            pred_target <= (lk_accept && lk_hit[1]) ? lk_entry[TGT_MSB:TGT_LSB] : '0;
        end
    end

endmodule
